// File: rtl/conv_sched.sv
// Kernel-load and raster-tracking controller that sequences one conv_block.
// Loads a KxK kernel serially into shadow registers, then flags complete line-buffer windows.
module conv_sched #(
  parameter int NBIT        = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_W       = 640,
  parameter int IMG_H       = 480
) (
  input  logic                                                 i_clk,
  input  logic                                                 i_rst,
  input  logic [NBIT-1:0]                                      i_coef,
  input  logic                                                 i_coef_valid,
  output logic                                                 o_coef_ready,
  output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0]    o_kernel,
  output logic                                                 o_kernel_valid,
  input  logic                                                 i_pix_valid,
  output logic                                                 o_pix_ready,
  output logic                                                 o_win_valid,
  output logic [$clog2(IMG_H)-1:0]                             o_row,
  output logic [$clog2(IMG_W)-1:0]                             o_col,
  output logic                                                 o_frame_done,
  output logic                                                 o_busy
);

  localparam int KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int IDX_W = (KK > 1) ? $clog2(KK) : 1;
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, RUN} state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [COL_W-1:0]           col_q, col_d;
  logic [KK-1:0][NBIT-1:0]    kernel_q, kernel_d;
  logic                       win_q, win_d;
  logic                       done_q, done_d;

  logic coef_acc, pix_acc, at_origin, last_col, last_row;

  // NOTE: combinational blocks use blocking '=' and assign every target a default first,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    row_d        = row_q;
    col_d        = col_q;
    kernel_d     = kernel_q;
    win_d        = 1'b0;
    done_d       = 1'b0;
    o_coef_ready = 1'b0;

    at_origin = (row_q == '0) && (col_q == '0);
    last_col  = (col_q == COL_W'(IMG_W - 1));
    last_row  = (row_q == ROW_W'(IMG_H - 1));

    case (state_q)
      IDLE, LOAD: o_coef_ready = 1'b1;
      RUN:        o_coef_ready = at_origin;
      default:    o_coef_ready = 1'b0;
    endcase

    // A coefficient at the frame boundary takes priority and stalls the pixel.
    coef_acc    = i_coef_valid && o_coef_ready;
    o_pix_ready = (state_q == RUN) && !coef_acc;
    pix_acc     = i_pix_valid && o_pix_ready;

    if (state_q == COMMIT) state_d = RUN;

    if (coef_acc) begin
      kernel_d[idx_q] = i_coef;
      if (idx_q == IDX_W'(KK - 1)) begin
        idx_d   = '0;
        state_d = COMMIT;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = LOAD;
      end
    end

    if (pix_acc) begin
      win_d  = (row_q >= ROW_W'(KERNEL_SIZE - 1)) && (col_q >= COL_W'(KERNEL_SIZE - 1));
      done_d = last_row && last_col;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // NOTE: the shadow kernel is a register bank, not a RAM, and is cleared by reset so
  // conv_block never sees stale coefficients after a reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      kernel_q <= '0;
      win_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      kernel_q <= kernel_d;
      win_q    <= win_d;
      done_q   <= done_d;
    end
  end

  assign o_kernel       = kernel_q;
  assign o_kernel_valid = (state_q == COMMIT);
  assign o_win_valid    = win_q;
  assign o_frame_done   = done_q;
  assign o_row          = row_q;
  assign o_col          = col_q;
  assign o_busy         = (state_q == LOAD) || (state_q == COMMIT);

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched on an 8x4 image with a 3x3 kernel.
module tb_conv_sched;
  localparam int NBIT = 8;
  localparam int K    = 3;
  localparam int W    = 8;
  localparam int H    = 4;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [NBIT-1:0]                 i_coef;
  logic                            i_coef_valid;
  logic                            o_coef_ready;
  logic [K-1:0][K-1:0][NBIT-1:0]   o_kernel;
  logic                            o_kernel_valid;
  logic                            i_pix_valid;
  logic                            o_pix_ready;
  logic                            o_win_valid;
  logic [$clog2(H)-1:0]            o_row;
  logic [$clog2(W)-1:0]            o_col;
  logic                            o_frame_done;
  logic                            o_busy;

  always #5 clk = ~clk;

  conv_sched #(.NBIT(NBIT), .KERNEL_SIZE(K), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_coef(i_coef), .i_coef_valid(i_coef_valid), .o_coef_ready(o_coef_ready),
    .o_kernel(o_kernel), .o_kernel_valid(o_kernel_valid),
    .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .o_win_valid(o_win_valid),
    .o_row(o_row), .o_col(o_col), .o_frame_done(o_frame_done), .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            cv;
    logic [NBIT-1:0] coef;
    logic            pv;
    logic            exp_cr;
    logic            exp_pr;
    logic            exp_busy;
    logic            exp_kv;
  } vec_t;

  vec_t vecs[11];

  // Reference raster model
  int   mr, mc, wins, dones, acc_cnt, first_win_acc;
  logic exp_win, exp_done;

  task automatic model_reset();
    mr = 0; mc = 0; exp_win = 1'b0; exp_done = 1'b0;
  endtask

  task automatic pix_cycle(input logic pv);
    @(negedge clk);
    i_coef_valid = 1'b0;
    i_pix_valid  = pv;
    #1;
    check("win_valid", o_win_valid, exp_win);
    check("frame_done", o_frame_done, exp_done);
    check("row", o_row, mr);
    check("col", o_col, mc);
    check("pix_ready", o_pix_ready, 1'b1);
    if (o_win_valid === 1'b1) begin
      if (wins == 0) first_win_acc = acc_cnt;
      wins++;
    end
    if (o_frame_done === 1'b1) dones++;
    exp_win  = pv && (mr >= K - 1) && (mc >= K - 1);
    exp_done = pv && (mr == H - 1) && (mc == W - 1);
    if (pv) begin
      acc_cnt++;
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
  endtask

  task automatic run_frame(input bit gaps);
    wins = 0; dones = 0; acc_cnt = 0; first_win_acc = -1;
    for (int i = 0; i < 400 && acc_cnt < W * H; i++)
      pix_cycle(gaps ? 1'($urandom_range(0, 1)) : 1'b1);
    pix_cycle(1'b0);
    check("frame accepts", acc_cnt, W * H);
    check("window count", wins, (H - K + 1) * (W - K + 1));
    check("frame_done count", dones, 1);
    check("first window after accept", first_win_acc, (K - 1) * W + K);
    check("row wrap", o_row, 0);
    check("col wrap", o_col, 0);
  endtask

  task automatic load_kernel(input int base);
    for (int k = 0; k < K * K; k++) begin
      @(negedge clk);
      i_coef_valid = 1'b1;
      i_coef       = NBIT'(base + k);
      i_pix_valid  = 1'b0;
    end
    @(negedge clk);
    i_coef_valid = 1'b0;
    #1;
    check("commit pulse", o_kernel_valid, 1'b1);
    @(negedge clk);
    #1;
    check("commit pulse ends", o_kernel_valid, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " kernel"}, o_kernel, '0);
    check({tag, " pix_ready"}, o_pix_ready, 1'b0);
    check({tag, " kernel_valid"}, o_kernel_valid, 1'b0);
    check({tag, " win_valid"}, o_win_valid, 1'b0);
    check({tag, " frame_done"}, o_frame_done, 1'b0);
    check({tag, " busy"}, o_busy, 1'b0);
    check({tag, " row"}, o_row, 0);
    check({tag, " col"}, o_col, 0);
  endtask

  initial begin
    // cv, coef, pv, exp coef_ready, pix_ready, busy, kernel_valid
    vecs[0] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 1; k < 9; k++)
      vecs[k] = '{1'b1, NBIT'(k + 1), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; i_coef = '0; i_coef_valid = 1'b0; i_pix_valid = 1'b0;
    #12;
    check_cleared("reset");
    check("reset coef_ready", o_coef_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Initial kernel load, one cycle per table row
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      i_coef_valid = vecs[i].cv;
      i_coef       = vecs[i].coef;
      i_pix_valid  = vecs[i].pv;
      #1;
      check($sformatf("v%0d coef_ready", i), o_coef_ready, vecs[i].exp_cr);
      check($sformatf("v%0d pix_ready", i), o_pix_ready, vecs[i].exp_pr);
      check($sformatf("v%0d busy", i), o_busy, vecs[i].exp_busy);
      check($sformatf("v%0d kernel_valid", i), o_kernel_valid, vecs[i].exp_kv);
    end
    check("kernel[0][0]", o_kernel[0][0], 1);
    check("kernel[1][2]", o_kernel[1][2], 6);
    check("kernel[2][2]", o_kernel[2][2], 9);
    check("kernel[2][0]", o_kernel[2][0], 7);

    model_reset();
    run_frame(1'b0);
    run_frame(1'b1);

    // Frame boundary: coefficient wins over a simultaneous pixel
    @(negedge clk);
    i_coef_valid = 1'b1; i_coef = 8'd11; i_pix_valid = 1'b1;
    #1;
    check("boundary coef_ready", o_coef_ready, 1'b1);
    check("boundary pix_ready", o_pix_ready, 1'b0);
    for (int k = 1; k < 9; k++) begin
      @(negedge clk);
      i_coef = NBIT'(11 + k);
      #1;
      check("load pix_ready", o_pix_ready, 1'b0);
    end
    @(negedge clk);
    i_coef_valid = 1'b0;
    #1;
    check("boundary commit", o_kernel_valid, 1'b1);
    check("boundary row held", o_row, 0);
    check("boundary col held", o_col, 0);
    model_reset();
    pix_cycle(1'b1);
    pix_cycle(1'b1);
    check("reload kernel[0][0]", o_kernel[0][0], 11);
    check("reload kernel[2][2]", o_kernel[2][2], 19);

    // Mid-frame coefficient is refused; pixels keep flowing
    for (int i = 0; i < 9; i++) pix_cycle(1'b1);
    @(negedge clk);
    i_coef_valid = 1'b1; i_coef = 8'hAA; i_pix_valid = 1'b1;
    #1;
    check("midframe row", o_row, 1);
    check("midframe col", o_col, 3);
    check("midframe coef_ready", o_coef_ready, 1'b0);
    check("midframe pix_ready", o_pix_ready, 1'b1);
    @(negedge clk);
    i_coef_valid = 1'b0; i_pix_valid = 1'b0;
    #1;
    check("midframe col advance", o_col, 4);
    check("midframe kernel kept", o_kernel[0][0], 11);
    check("midframe busy", o_busy, 1'b0);
    mr = 1; mc = 4; exp_win = 1'b0; exp_done = 1'b0;

    // Async reset mid-frame while a window pulse is high
    for (int i = 0; i < 8; i++) pix_cycle(1'b1);
    @(negedge clk);
    i_pix_valid = 1'b0;
    #1;
    check("pre-reset win_valid", o_win_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_cleared("midframe reset");
    @(negedge clk);
    rst = 1'b0;

    // Async reset during a partial load, then a clean reload
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      i_coef_valid = 1'b1; i_coef = NBIT'(k);
    end
    @(negedge clk);
    i_coef_valid = 1'b0;
    #1;
    check("partial busy", o_busy, 1'b1);
    check("partial kernel[1][1]", o_kernel[1][1], 5);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("partial reset");
    @(negedge clk);
    rst = 1'b0;
    load_kernel(21);
    check("post-reset kernel[0][0]", o_kernel[0][0], 21);
    check("post-reset kernel[1][2]", o_kernel[1][2], 26);
    check("post-reset kernel[2][2]", o_kernel[2][2], 29);
    check("post-reset pix_ready", o_pix_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
